// File: rtl/axis_addr_expand_pkg.sv
// Shared types and constants for the AXI address-burst expander.
package axis_addr_expand_pkg;

   localparam int DEF_BEAT_BYTES = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Packed FIFO command layout is {id, addr, len}.
   function automatic int cmd_width(input int id_w, input int addr_w, input int len_w);
      return id_w + addr_w + len_w;
   endfunction

endpackage

// File: rtl/axis_addr_expand_if.sv
// Address-burst input channel plus beat-command output channel.
interface axis_addr_expand_if #(
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_LEN_WIDTH  = 8
);
   logic [AXI_ID_WIDTH-1:0]   axi_aid;
   logic [AXI_ADDR_WIDTH-1:0] axi_aaddr;
   logic [AXI_LEN_WIDTH-1:0]  axi_alen;
   logic                      axi_avalid;
   logic                      axi_aready;
   logic [AXI_ID_WIDTH-1:0]   beat_id;
   logic [AXI_ADDR_WIDTH-1:0] beat_addr;
   logic                      beat_last;
   logic                      beat_valid;
   logic                      beat_ready;

   modport master (
      output axi_aid, axi_aaddr, axi_alen, axi_avalid, beat_ready,
      input  axi_aready, beat_id, beat_addr, beat_last, beat_valid
   );

   modport slave (
      input  axi_aid, axi_aaddr, axi_alen, axi_avalid, beat_ready,
      output axi_aready, beat_id, beat_addr, beat_last, beat_valid
   );
endinterface

// File: rtl/axis_cmd_fifo.sv
// Small synchronous FIFO; head entry is readable without a pop cycle.
module axis_cmd_fifo #(
   parameter int WIDTH      = 48,
   parameter int CMD_AWIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int DEPTH = 1 << CMD_AWIDTH;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [CMD_AWIDTH:0] r_wptr;
   logic [CMD_AWIDTH:0] r_rptr;
   logic                w_push;
   logic                w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[CMD_AWIDTH] != r_rptr[CMD_AWIDTH]) &&
                    (r_wptr[CMD_AWIDTH-1:0] == r_rptr[CMD_AWIDTH-1:0]);
   assign o_data  = r_mem[r_rptr[CMD_AWIDTH-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[CMD_AWIDTH-1:0]] <= i_data;
   end
endmodule

// File: rtl/axis_addr_expand.sv
// Queues AXI address bursts and expands each into per-beat address/id/last commands.
module axis_addr_expand
   import axis_addr_expand_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int BEAT_BYTES     = DEF_BEAT_BYTES,
   parameter int CMD_AWIDTH     = 2
) (
   input  logic               clk,
   input  logic               rst,
   axis_addr_expand_if.slave  s_if,
   output logic               busy
);
   localparam int CMD_W = cmd_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_LEN_WIDTH);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_LEN_WIDTH-1:0]  r_len;
   logic [AXI_LEN_WIDTH-1:0]  r_cnt;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_push;
   logic                      w_load;
   logic                      w_adv;
   logic                      w_last;
   logic                      w_hs;
   logic [CMD_W-1:0]          w_head;
   logic [AXI_ID_WIDTH-1:0]   w_hid;
   logic [AXI_ADDR_WIDTH-1:0] w_haddr;
   logic [AXI_LEN_WIDTH-1:0]  w_hlen;

   // aready is combinationally gated by reset so it drops the instant rst asserts.
   assign s_if.axi_aready = rst & ~w_full;
   assign w_push          = s_if.axi_avalid & s_if.axi_aready;

   axis_cmd_fifo #(
      .WIDTH      (CMD_W),
      .CMD_AWIDTH (CMD_AWIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({s_if.axi_aid, s_if.axi_aaddr, s_if.axi_alen}),
      .i_pop   (w_load),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign {w_hid, w_haddr, w_hlen} = w_head;

   assign w_last = (r_state == ST_BURST) && (r_cnt == r_len);
   assign w_hs   = (r_state == ST_BURST) && s_if.beat_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_load      = 1'b1;
               w_state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (w_hs) begin
               // On the last beat chain straight into the next burst if one is queued.
               if (!w_last)       w_adv       = 1'b1;
               else if (!w_empty) w_load      = 1'b1;
               else               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
         r_id   <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_addr <= w_haddr;
         r_id   <= w_hid;
         r_len  <= w_hlen;
         r_cnt  <= '0;
      end else if (w_adv) begin
         r_addr <= r_addr + AXI_ADDR_WIDTH'(BEAT_BYTES);
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign s_if.beat_valid = (r_state == ST_BURST);
   assign s_if.beat_last  = w_last;
   assign s_if.beat_addr  = r_addr;
   assign s_if.beat_id    = r_id;
   assign busy            = ~w_empty | (r_state == ST_BURST);
endmodule

// File: tb/tb_axis_addr_expand.sv
// Randomized bench for axis_addr_expand against a burst-to-beat queue model.
module tb_axis_addr_expand;
   logic clk;
   logic rst;
   logic busy;

   axis_addr_expand_if #(.AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(32), .AXI_LEN_WIDTH(8)) vif ();

   axis_addr_expand #(
      .AXI_ID_WIDTH   (8),
      .AXI_LEN_WIDTH  (8),
      .AXI_ADDR_WIDTH (32),
      .BEAT_BYTES     (32),
      .CMD_AWIDTH     (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .s_if (vif),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] addr;
      logic        last;
      logic        first;
   } beat_t;

   beat_t q[$];
   int    n_unst;
   logic  exp_v;
   bit    acc;
   bit    rnd_ready;
   int    n_tests;
   int    n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: sample at negedge+1, compare with the model, then update it.
   task automatic cyc();
      bit   hs;
      bit   lst;
      int   l;
      logic [31:0] a;
      if (rnd_ready) vif.beat_ready = 1'($urandom_range(0, 1));
      #1;
      acc = 0;
      chk("valid", vif.beat_valid, exp_v);
      if (vif.beat_valid && q.size() != 0 && q[0].first) begin
         n_unst--;
         q[0].first = 1'b0;
      end
      chk("aready", vif.axi_aready, n_unst < 4);
      chk("busy", busy, q.size() != 0);
      hs  = vif.beat_valid && vif.beat_ready;
      lst = 0;
      if (vif.beat_valid) begin
         if (q.size() == 0) chk("beat_spurious", 1, 0);
         else begin
            chk("beat", {vif.beat_id, vif.beat_addr, vif.beat_last}, {q[0].id, q[0].addr, q[0].last});
            lst = q[0].last;
            if (hs) void'(q.pop_front());
         end
      end
      exp_v = (vif.beat_valid && !hs) || (hs && !lst) || (n_unst > 0);
      if (vif.axi_avalid && vif.axi_aready) begin
         acc = 1;
         n_unst++;
         l = int'(vif.axi_alen);
         for (int i = 0; i <= l; i++) begin
            a = vif.axi_aaddr + 32'(i * 32);
            q.push_back('{vif.axi_aid, a, (i == l), (i == 0)});
         end
      end
      @(negedge clk);
   endtask

   task automatic offer(input logic [7:0] id, input logic [31:0] a, input logic [7:0] l,
                        input int budget, output bit ok);
      vif.axi_aid    = id;
      vif.axi_aaddr  = a;
      vif.axi_alen   = l;
      vif.axi_avalid = 1'b1;
      ok = 0;
      for (int k = 0; k < budget && !ok; k++) begin
         cyc();
         ok = acc;
      end
      vif.axi_avalid = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int k;
      k = 0;
      rnd_ready = rnd;
      if (!rnd) vif.beat_ready = 1'b1;
      while ((q.size() != 0 || exp_v) && k < 2000) begin
         cyc();
         k++;
      end
      chk("drain_bound", k < 2000, 1);
      cyc();
      rnd_ready = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"},  vif.beat_valid, 0);
      chk({tag, "_aready"}, vif.axi_aready, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_last"},   vif.beat_last, 0);
      chk({tag, "_addr"},   vif.beat_addr, 0);
      chk({tag, "_id"},     vif.beat_id, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      n_tests = 0; n_fail = 0; n_unst = 0; exp_v = 0; rnd_ready = 0;
      rst = 1'b0;
      vif.axi_aid = '0; vif.axi_aaddr = '0; vif.axi_alen = '0;
      vif.axi_avalid = 1'b0; vif.beat_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("rst");
      rst = 1'b1;
      @(negedge clk);

      // Single burst, ready held high
      vif.beat_ready = 1'b1;
      offer(8'd3, 32'h1000, 8'd3, 10, ok);
      chk("single_acc", ok, 1);
      drain(0);

      // Two queued bursts expand with no gap
      vif.beat_ready = 1'b0;
      offer(8'd1, 32'h0, 8'd1, 10, ok);
      offer(8'd2, 32'h2000, 8'd0, 10, ok);
      drain(0);

      // Random backpressure on a len=7 burst
      offer(8'd4, 32'h3000, 8'd7, 10, ok);
      drain(1);

      // Fill the FIFO with ready low; the sixth burst must be refused
      vif.beat_ready = 1'b0;
      for (int i = 0; i < 5; i++) offer(8'(16 + i), 32'h8000 + 32'(i * 256), 8'd0, 3, ok);
      offer(8'd21, 32'h9000, 8'd2, 3, ok);
      chk("full_refused", ok, 0);
      vif.beat_ready = 1'b1;
      cyc();
      vif.beat_ready = 1'b0;
      offer(8'd21, 32'h9000, 8'd2, 3, ok);
      chk("full_reaccept", ok, 1);
      drain(0);

      // Address wrap and maximum length
      offer(8'd7, 32'hFFFF_FFE0, 8'd1, 10, ok);
      drain(0);
      offer(8'd8, $urandom, 8'd255, 10, ok);
      drain(0);

      // Reset in the middle of a burst
      vif.beat_ready = 1'b1;
      offer(8'd5, 32'h5000, 8'd7, 10, ok);
      for (int k = 0; k < 20 && q.size() > 6; k++) cyc();
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      q.delete();
      n_unst = 0;
      exp_v  = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      offer(8'd9, 32'h400, 8'd2, 10, ok);
      chk("post_rst_acc", ok, 1);
      drain(0);

      // Random traffic with unaligned addresses and random ready
      rnd_ready = 1;
      for (int n = 0; n < 25; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) cyc();
         offer(8'($urandom), $urandom, 8'($urandom_range(0, 7)), 60, ok);
         chk("rand_acc", ok, 1);
      end
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
